// File: rtl/msg_padder_if.sv
// Handshake bundle between a message source, the padder and the hash core.
//   in_*  : upstream word stream (valid/ready, big-endian data, last + byte count)
//   out_* : padded 32-bit words toward the hash core (valid/ready, block markers)
// master = source/sink side (testbench or surrounding logic), slave = padder.
interface msg_padder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [2:0]  in_nbytes;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_first;
  logic        out_msg_last;

  modport master (
    output in_valid, in_data, in_last, in_nbytes, out_ready,
    input  in_ready, out_valid, out_data, out_first, out_msg_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_nbytes, out_ready,
    output in_ready, out_valid, out_data, out_first, out_msg_last
  );
endinterface

// File: rtl/msg_padder.sv
// SHA-2 style message padder (32-bit words, 512-bit blocks, 64-bit length).
// Forwards message words, inserts the 0x80 marker, zero-fills to word 14 of
// a block (spilling into an extra block when needed) and appends the 64-bit
// bit length. One registered output stage; latency 1 cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : msg_padder_if.slave (in_* upstream stream, out_* to hash core)
module msg_padder (
  input logic         clk,
  input logic         reset,
  msg_padder_if.slave bus
);

  typedef enum logic [2:0] {STREAM, PAD80, ZERO, LENHI, LENLO} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wcnt, wcnt_nxt;     // index of the next word to be emitted
  logic [63:0] bcnt, bcnt_nxt;     // message length in bits
  logic        ov, ov_nxt;
  logic [31:0] od, od_nxt;
  logic        of, of_nxt;
  logic        ol, ol_nxt;

  logic        slot;               // output register free for a new word
  logic        load;
  logic        msg_last;
  logic [31:0] word;
  logic [2:0]  nb;                 // clamped byte count 0..4
  logic [31:0] tail_word;          // last input word with 0x80 marker applied
  logic [3:0]  wcnt_inc;
  state_t      after_pad;          // where to go once the 0x80 byte is out

  assign slot         = !ov || bus.out_ready;
  assign bus.in_ready = reset && (state == STREAM) && slot;
  assign nb           = (bus.in_nbytes > 3'd4) ? 3'd4 : bus.in_nbytes;
  assign wcnt_inc     = wcnt + 4'd1;
  assign after_pad    = (wcnt_inc == 4'd14) ? LENHI : ZERO;

  assign bus.out_valid    = ov;
  assign bus.out_data     = od;
  assign bus.out_first    = of;
  assign bus.out_msg_last = ol;

  // Keep bytes below nb, put 0x80 at byte nb, clear the rest.
  always_comb begin
    tail_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(nb))
        tail_word[31-8*i -: 8] = bus.in_data[31-8*i -: 8];
      else if (i == int'(nb))
        tail_word[31-8*i -: 8] = 8'h80;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    bcnt_nxt  = bcnt;
    ov_nxt    = ov && !bus.out_ready;   // drop valid once the beat is taken
    od_nxt    = od;
    of_nxt    = of;
    ol_nxt    = ol;
    load      = 1'b0;
    msg_last  = 1'b0;
    word      = '0;

    unique case (state)
      STREAM: begin
        if (bus.in_valid && bus.in_ready) begin
          load = 1'b1;
          if (bus.in_last) begin
            bcnt_nxt = bcnt + 64'({nb, 3'b000});
            if (nb == 3'd4) begin
              word      = bus.in_data;
              state_nxt = PAD80;
            end else begin
              word      = tail_word;
              state_nxt = after_pad;
            end
          end else begin
            word     = bus.in_data;
            bcnt_nxt = bcnt + 64'd32;
          end
        end
      end
      PAD80: if (slot) begin
        load      = 1'b1;
        word      = 32'h8000_0000;
        state_nxt = after_pad;
      end
      ZERO: if (slot) begin
        load      = 1'b1;
        state_nxt = after_pad;
      end
      LENHI: if (slot) begin
        load      = 1'b1;
        word      = bcnt[63:32];
        state_nxt = LENLO;
      end
      LENLO: if (slot) begin
        // Counter is already at 15 here, so it wraps to 0 with this beat.
        load      = 1'b1;
        word      = bcnt[31:0];
        msg_last  = 1'b1;
        bcnt_nxt  = '0;
        state_nxt = STREAM;
      end
      default: state_nxt = STREAM;
    endcase

    if (load) begin
      ov_nxt   = 1'b1;
      od_nxt   = word;
      of_nxt   = (wcnt == 4'd0);
      ol_nxt   = msg_last;
      wcnt_nxt = wcnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= STREAM;
      wcnt  <= '0;
      bcnt  <= '0;
      ov    <= 1'b0;
      od    <= '0;
      of    <= 1'b0;
      ol    <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      bcnt  <= bcnt_nxt;
      ov    <= ov_nxt;
      od    <= od_nxt;
      of    <= of_nxt;
      ol    <= ol_nxt;
    end
  end

endmodule

// File: doc/msg_padder.md
MSG_PADDER -- requirements
Module: msg_padder

Interface
REQ-001 Parameters: none; all widths fixed (32-bit words, 512-bit blocks, 64-bit length field).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-low; clears all state when sampled low.
REQ-004 in_valid  input  1  upstream word present.
REQ-005 in_ready  output  1  padder accepts in_data this cycle.
REQ-006 in_data  input  32  message word, big-endian: byte 0 in [31:24].
REQ-007 in_last  input  1  final word of the current message.
REQ-008 in_nbytes  input  3  count of valid bytes in a last word, 0..4; sampled only with in_last; values 5..7 are treated as 4.
REQ-009 out_valid  output  1  out_data valid toward the hash core.
REQ-010 out_ready  input  1  hash core accepts out_data.
REQ-011 out_data  output  32  padded message word (this is the core's msg input).
REQ-012 out_first  output  1  out_data is word 0 of a 512-bit block.
REQ-013 out_msg_last  output  1  out_data is word 15 of the final block of a message.

Function
REQ-014 Transfer rule: a beat moves on either port only when valid and ready are both high on the same rising edge.
REQ-015 Single registered output stage: out_valid, out_data, out_first and out_msg_last come from flops; input-to-output latency is exactly 1 cycle.
REQ-016 in_ready = (state == STREAM) && (!out_valid || out_ready).
REQ-017 While out_valid is high and out_ready is low, all out_* signals are held stable.
REQ-018 States: STREAM, PAD80, ZERO, LENHI, LENLO; exit state after reset is STREAM.
REQ-019 A 4-bit word counter tracks the position in the block: +1 per output beat, wraps 15->0; out_first = (counter == 0).
REQ-020 A 64-bit bit counter adds 32 per accepted non-last word and 8*in_nbytes per accepted last word, modulo 2^64.
REQ-021 STREAM, non-last word: in_data is forwarded unchanged.
REQ-022 STREAM, last word with in_nbytes = 4: the word is forwarded unchanged; next state PAD80.
REQ-023 STREAM, last word with in_nbytes = n < 4: the output keeps bytes 0..n-1, sets byte n to 0x80, and zeroes the remaining bytes. n = 0 yields 0x80000000; this is how an empty message is sent.
REQ-024 After the word in REQ-023: next state is LENHI if the word counter then equals 14, otherwise ZERO.
REQ-025 PAD80 emits 0x80000000; next state follows the rule of REQ-024.
REQ-026 ZERO emits 0x00000000 and repeats until the word counter equals 14, wrapping through a full extra block when required; next state LENHI.
REQ-027 Extra block: if the 0x80 byte lands in word 14 or 15, zeros fill that block and a second block carries words 0..13 zero plus the length.
REQ-028 LENHI emits bit_count[63:32]; LENLO emits bit_count[31:0] with out_msg_last = 1.
REQ-029 When the LENLO beat transfers: bit counter clears, word counter is 0, state returns to STREAM. A new message may be accepted in that same cycle's successor.
REQ-030 A last word accepted at word counter 15 follows the same REQ-024 rule: the counter wraps to 0 and the result goes to ZERO.
REQ-031 out_msg_last = 0 on every beat except LENLO.

Reset
REQ-032 When reset is low at a rising edge, the next values are: out_valid 0, out_data 0, out_first 0, out_msg_last 0, state STREAM, both counters 0.
REQ-033 Reset has the same effect mid-message or mid-padding: partial message state is discarded and no further padding words are emitted.
REQ-034 in_ready is 0 during any cycle in which reset is sampled low.

Verification
REQ-035 "abc": one beat, in_data 0x61626300, in_last 1, in_nbytes 3.
- Required: 16 beats: 0x61626380, 14x 0x00000000, 0x00000018.
- out_first on beat 0; out_msg_last on beat 15.
REQ-036 Empty message: in_last 1, in_nbytes 0.
- Required: 0x80000000, 15x 0x00000000; last word 0x00000000 with out_msg_last 1.
REQ-037 Fourteen full words 0x00000001..0x0000000E, last with in_nbytes 4.
- Block 1: data words, then 0x80000000, then 0x00000000.
- Block 2: 15x 0, then 0x000001C0.
- Total 32 beats.
REQ-038 Backpressure: hold out_ready low for 5 cycles mid-stream.
- Required: out_data stable, in_ready 0 throughout; no word lost or duplicated.
- Compare against the golden sequence for random ready patterns.
REQ-039 Reset asserted low for 1 cycle during ZERO state.
- Required: out_valid 0 on the next cycle.
- A following "abc" message yields exactly the REQ-035 sequence.
REQ-040 Back-to-back messages: "abc", then a 55-byte message, with in_valid held high.
- Required: the second message's bit count is 0x000001B8 with a single-block pad.
- No idle beat is required between the two messages.
